pe_mac_os: RTL
==============

PE_MAC_OS -- requirements
Module: pe_mac_os

Interface
REQ-001 Parameter DATA_W, default 8: width of the u (weight) and l (data) operands.
REQ-002 Parameter ACC_W, default 24: accumulator and result width; SHALL satisfy ACC_W >= 2*DATA_W.
REQ-003 Parameter CNT_W, default 8: width of the tile-length counter.
REQ-004 Parameter SIGNED_MODE, default 1: 1 = two's-complement operands; 0 = unsigned.
REQ-005 Parameter SATURATE, default 1: 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_W.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse: begin a new tile and load k_len.
REQ-009 k_len  in  CNT_W  number of MACs in the tile; sampled only when start=1.
REQ-010 u_in / u_vld  in  DATA_W / 1  weight from the north neighbour and its valid.
REQ-011 l_in / l_vld  in  DATA_W / 1  data from the west neighbour and its valid.
REQ-012 d_out / d_vld  out  DATA_W / 1  registered weight and valid to the south neighbour.
REQ-013 r_out / r_vld  out  DATA_W / 1  registered data and valid to the east neighbour.
REQ-014 out / out_vld  out  ACC_W / 1  tile result and its one-cycle valid pulse.
REQ-015 busy  out  1  high while state = ACCUM.
REQ-016 sat_flag / err_flag  out  1 / 1  sticky saturation flag and sticky valid-mismatch flag.

Function
REQ-017 Forwarding: d_out, d_vld, r_out and r_vld SHALL equal u_in, u_vld, l_in and l_vld delayed by exactly 1 cycle, in every state and independent of start.
REQ-018 The block SHALL fire in a cycle when u_vld=1 and l_vld=1; the product u_in*l_in is 2*DATA_W wide, signed or unsigned per SIGNED_MODE, and extended to ACC_W.
REQ-019 The state machine SHALL have two states, IDLE and ACCUM.
REQ-020 IDLE + start with k_len>0 SHALL go to ACCUM with acc=0, cnt=0 and len=k_len, and SHALL clear sat_flag and err_flag.
REQ-021 IDLE + start with k_len=0 SHALL stay in IDLE and assert out=0, out_vld=1 on the next cycle.
REQ-022 ACCUM + fire SHALL set acc to acc+product (saturated or wrapped) and increment cnt.
REQ-023 ACCUM + fire with cnt=len-1 SHALL drive out to the final sum and out_vld=1 on the next cycle, then return to IDLE.
REQ-024 ACCUM + start SHALL abort the current tile without producing out_vld and restart per REQ-020; a fire in the same cycle SHALL count as MAC #1 of the new tile.
REQ-025 A fire in the same cycle as start from IDLE SHALL likewise count as MAC #1 of the new tile.
REQ-026 Fires in IDLE without start SHALL be forwarded but SHALL NOT accumulate.
REQ-027 In ACCUM, a cycle with exactly one of u_vld or l_vld high SHALL set err_flag, perform no MAC and not advance cnt.
REQ-028 With SATURATE=1, a sum above the ACC_W maximum (or below the minimum in signed mode) SHALL clamp to that limit and set sat_flag.
REQ-029 With SATURATE=0, the accumulator SHALL wrap and sat_flag SHALL stay 0.
REQ-030 out SHALL hold its last value between out_vld pulses; out_vld SHALL be high for exactly 1 cycle per completed tile.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE and acc, cnt, len, out, out_vld, d_out, d_vld, r_out, r_vld, busy, sat_flag and err_flag to 0.
REQ-032 A reset asserted mid-tile SHALL discard the tile; no out_vld SHALL follow deassertion.

Structure
REQ-033 The state encoding and a saturating-add function of (a, b, width, signed) SHALL reside in the shared package pe_pkg.
REQ-034 The product/accumulate datapath SHALL be a single sub-module pe_mac_unit (multiply, extend, saturating add); the FSM, counter and forwarding registers SHALL stay in pe_mac_os.

Verification
REQ-035 Default parameters, start with k_len=3, pairs (2,3),(4,5),(-1,7) -> out=19, out_vld 1 cycle after the third fire, then busy=0.
REQ-036 DATA_W=8, ACC_W=16, signed, k_len=4 with all pairs (127,127) -> out=32767 and sat_flag=1; the same stimulus with SATURATE=0 -> out=64516 mod 65536 = 64516 wrapped to signed -1020 and sat_flag=0.
REQ-037 k_len=4, two fires, start with k_len=2 and a fire (3,3) in the same cycle, then one fire (1,1) -> out=10, no out_vld for the aborted tile.
REQ-038 Gapped valids (u_vld only on cycle 2) during k_len=2 -> err_flag=1, cnt unchanged, and the result equals the sum of the two true fires.
REQ-039 Random u/l stream -> d_out/r_out equal the inputs delayed by 1 cycle in all states; rst pulsed low mid-tile -> all outputs 0 within the same cycle and no out_vld afterwards.
REQ-040 start with k_len=0 -> out=0 with out_vld=1 on the next cycle and busy never asserted.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary MAC processing element.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   pe_state_e  - two-state tile controller encoding (IDLE / ACCUM)
//   sat_add     - width-generic add of two operands, clamped to the range of
//                 a 'width'-bit signed or unsigned number
//   sat_ovf     - companion predicate: would sat_add have clamped?
// Operands are passed zero-padded in 64-bit containers and only their low
// 'width' bits are meaningful; width must be below 64.
package pe_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } pe_state_e;

    // Low-'width'-bit mask.
    function automatic logic [63:0] width_mask(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // Re-extend a 'width'-bit value held in a 64-bit container so that
    // 64-bit arithmetic on it is exact.
    function automatic logic [63:0] ext64(input logic [63:0] a, input int width,
                                          input logic is_signed);
        logic [63:0] mask;
        mask = width_mask(width);
        if (is_signed && (((a >> (width - 1)) & 64'd1) != 64'd0))
            return a | ~mask;
        return a & mask;
    endfunction

    // a + b clamped to the representable range of a 'width'-bit number.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width, input logic is_signed);
        logic [63:0] mask;
        logic [63:0] hi;
        logic [63:0] lo;
        logic [63:0] s;
        mask = width_mask(width);
        s    = ext64(a, width, is_signed) + ext64(b, width, is_signed);
        if (is_signed) begin
            hi = mask >> 1;
            lo = ~hi;
            if ($signed(s) > $signed(hi))
                s = hi;
            else if ($signed(s) < $signed(lo))
                s = lo;
        end else begin
            if (s > mask)
                s = mask;
        end
        return s & mask;
    endfunction

    // True when a + b falls outside the 'width'-bit range.
    function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input int width, input logic is_signed);
        logic [63:0] mask;
        logic [63:0] hi;
        logic [63:0] s;
        mask = width_mask(width);
        s    = ext64(a, width, is_signed) + ext64(b, width, is_signed);
        if (is_signed) begin
            hi = mask >> 1;
            return ($signed(s) > $signed(hi)) || ($signed(s) < $signed(~hi));
        end
        return s > mask;
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Multiply-accumulate datapath: sum = acc + ext(u * l), saturated or wrapped.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; evaluated every cycle, the caller decides whether to commit.
//
// Ports:
//   u, l  - DATA_W operands (two's-complement when SIGNED_MODE=1)
//   acc   - ACC_W running sum
//   sum   - ACC_W next sum
//   ovf   - sum was clamped (always 0 when SATURATE=0)
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 24,
    parameter int SIGNED_MODE = 1,
    parameter int SATURATE    = 1
) (
    input  logic [DATA_W-1:0] u,
    input  logic [DATA_W-1:0] l,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic IS_SIGNED = (SIGNED_MODE != 0);

    logic [ACC_W-1:0] prod_ext;

    // Full-precision product, then sign- or zero-extended to the accumulator.
    if (SIGNED_MODE != 0) begin : g_smul
        logic signed [2*DATA_W-1:0] prod;
        assign prod     = $signed(u) * $signed(l);
        assign prod_ext = ACC_W'(prod);
    end else begin : g_umul
        logic [2*DATA_W-1:0] prod;
        assign prod     = u * l;
        assign prod_ext = ACC_W'(prod);
    end

    if (SATURATE != 0) begin : g_sat
        assign sum = ACC_W'(sat_add(64'(acc), 64'(prod_ext), ACC_W, IS_SIGNED));
        assign ovf = sat_ovf(64'(acc), 64'(prod_ext), ACC_W, IS_SIGNED);
    end else begin : g_wrap
        // Modulo-2^ACC_W arithmetic is identical for signed and unsigned.
        assign sum = acc + prod_ext;
        assign ovf = 1'b0;
    end

endmodule

// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE: forwards u/l one hop and accumulates a k_len-long dot product.
// Latency: forwarding 1 cycle; result 1 cycle after the last MAC (or after start when k_len=0).
// Backpressure: none; operands are consumed on every cycle both valids are high.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start, k_len      - begin a tile of k_len MACs (k_len sampled with start)
//   u_in/u_vld        - weight from north;  d_out/d_vld - weight to south (+1 cycle)
//   l_in/l_vld        - data from west;     r_out/r_vld - data to east   (+1 cycle)
//   out/out_vld       - tile result, one-cycle valid; out holds between tiles
//   busy              - tile in progress
//   sat_flag/err_flag - sticky clamp / one-sided-valid indicators, cleared by start
module pe_mac_os
    import pe_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 24,
    parameter int CNT_W       = 8,
    parameter int SIGNED_MODE = 1,
    parameter int SATURATE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  k_len,
    input  logic [DATA_W-1:0] u_in,
    input  logic              u_vld,
    input  logic [DATA_W-1:0] l_in,
    input  logic              l_vld,
    output logic [DATA_W-1:0] d_out,
    output logic              d_vld,
    output logic [DATA_W-1:0] r_out,
    output logic              r_vld,
    output logic [ACC_W-1:0]  out,
    output logic              out_vld,
    output logic              busy,
    output logic              sat_flag,
    output logic              err_flag
);

    pe_state_e        state;
    pe_state_e        nxt_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;

    logic             fire;
    logic             mismatch;
    logic             in_tile;
    logic             do_mac;
    logic             last_mac;
    logic [ACC_W-1:0] acc_src;
    logic [CNT_W-1:0] cnt_src;
    logic [CNT_W-1:0] len_src;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_ovf;

    assign fire     = u_vld & l_vld;
    assign mismatch = u_vld ^ l_vld;

    // A start cycle is already part of the new tile: the MAC in that cycle
    // sees a cleared accumulator and counter and the freshly sampled length.
    assign acc_src  = start ? '0    : acc;
    assign cnt_src  = start ? '0    : cnt;
    assign len_src  = start ? k_len : len;
    assign in_tile  = start ? (k_len != '0) : (state == ST_ACCUM);
    assign do_mac   = fire & in_tile;
    assign last_mac = (CNT_W'(cnt_src + 1'b1) == len_src);

    pe_mac_unit #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .SIGNED_MODE (SIGNED_MODE),
        .SATURATE    (SATURATE)
    ) u_mac (
        .u   (u_in),
        .l   (l_in),
        .acc (acc_src),
        .sum (mac_sum),
        .ovf (mac_ovf)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= nxt_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt_state = state;
        if (start) begin
            // A one-MAC tile whose only fire arrives with start finishes at once.
            if ((k_len != '0) && !(do_mac && last_mac))
                nxt_state = ST_ACCUM;
            else
                nxt_state = ST_IDLE;
        end else if ((state == ST_ACCUM) && do_mac && last_mac) begin
            nxt_state = ST_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ST_ACCUM);
    end

    // ---------------- accumulator, counter, result ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            cnt      <= '0;
            len      <= '0;
            out      <= '0;
            out_vld  <= 1'b0;
            sat_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            if (start) begin
                acc      <= '0;
                cnt      <= '0;
                len      <= k_len;
                sat_flag <= 1'b0;
                err_flag <= 1'b0;
                if (k_len == '0) begin
                    out     <= '0;
                    out_vld <= 1'b1;
                end
            end
            if (do_mac) begin
                acc <= mac_sum;
                cnt <= CNT_W'(cnt_src + 1'b1);
                if (mac_ovf)
                    sat_flag <= 1'b1;
                if (last_mac) begin
                    out     <= mac_sum;
                    out_vld <= 1'b1;
                end
            end
            // One-sided valid inside a tile: no MAC, counter holds, flag it.
            if (mismatch && in_tile)
                err_flag <= 1'b1;
        end
    end

    // ---------------- neighbour forwarding ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
            d_vld <= 1'b0;
            r_out <= '0;
            r_vld <= 1'b0;
        end else begin
            d_out <= u_in;
            d_vld <= u_vld;
            r_out <= l_in;
            r_vld <= l_vld;
        end
    end

endmodule
